ps2_cmd_scheduler: RTL
======================

Name: ps2_cmd_scheduler

Overview:
Host-side command scheduler for the PS/2 keyboard link. It arbitrates between two command requesters, such as game logic setting LEDs and a debug/config path. It sequences each 1- or 2-byte command through the shared PS/2 host-to-device byte transmitter and checks the device response bytes (0xFA ACK, 0xFE RESEND), with retry and timeout. Received bytes that are not consumed as command responses pass through to the scan-code path.

Parameters:
ACK_TIMEOUT, 800000, cycles to wait for the response byte after TX_DONE (20 ms at 40 MHz)
MAX_RETRY, 3, total send attempts per byte before the command is reported as failed

Ports:
CLK  in  1  system clock, 40 MHz
RESET  in  1  synchronous, active-high
REQ0  in  1  requester 0 command request; hold high until DONE0/ERR0
REQ0_LEN  in  1  0: one byte; 1: two bytes
REQ0_CMD  in  16  byte0 = [7:0] (sent first), byte1 = [15:8]
DONE0  out  1  1-cycle pulse: requester 0 command fully acknowledged
ERR0  out  1  1-cycle pulse: requester 0 command abandoned
REQ1, REQ1_LEN, REQ1_CMD, DONE1, ERR1  same as requester 0, for requester 1
TX_START  out  1  1-cycle pulse: start a host-to-device byte
TX_BYTE  out  8  byte to send; stable from TX_START until TX_DONE/TX_ERR
TX_DONE  in  1  pulse: transmitter finished and saw the device ack bit
TX_ERR  in  1  pulse: transmitter failed (no ack bit or line timeout)
RX_VALID  in  1  pulse: device byte received
RX_BYTE  in  8  received byte
KEY_VALID  out  1  pulse: forwarded scan byte
KEY_BYTE  out  8  forwarded byte; holds its last value
BUSY  out  1  high in every state except IDLE
INIT_DONE  out  1  boot configuration complete (see Optional Feature)

Behaviour:
- Reset: state IDLE; all outputs 0; rr_last = 1, so requester 0 wins the first tie; retry_cnt = 0; timer = 0; byte_idx = 0. Reset mid-command aborts at once with no DONE/ERR; requesters must re-request.
- IDLE: sample REQ0/REQ1.
  - Single requester: it is granted.
  - Both requesting: the one not equal to rr_last is granted.
  - On grant: latch CMD/LEN, set rr_last = grant, byte_idx = 0, retry_cnt = 0, go to SEND.
- SEND: TX_START = 1 for one cycle, TX_BYTE = latched byte[byte_idx]. Go to WAIT_TX.
- WAIT_TX:
  - TX_DONE: clear timer, go to WAIT_ACK.
  - TX_ERR: go to RETRY.
- WAIT_ACK: timer increments each cycle.
  - RX_VALID with 0xFA: if byte_idx == LEN, go to DONE; else byte_idx++, retry_cnt = 0, go to SEND.
  - RX_VALID with 0xFE: go to RETRY.
  - RX_VALID with any other byte: forward it, stay in WAIT_ACK.
  - timer == ACK_TIMEOUT-1 with no response: go to RETRY.
  - RX_VALID and timeout in the same cycle: the byte wins.
- RETRY: retry_cnt++.
  - If the new retry_cnt == MAX_RETRY: ERRx pulse, go to HOLD.
  - Otherwise: resend the same byte via SEND.
- DONE: DONEx pulse for one cycle, go to HOLD.
- HOLD: one cycle with REQ inputs ignored, so the requester can drop REQ. Then go to IDLE.
- Total minimum gap between commands: DONE + HOLD + IDLE = 3 cycles.
- REQx dropped mid-command is ignored: the command completes and reports DONE/ERR normally.
- Forwarding: every RX byte not consumed in WAIT_ACK, in any state, gives KEY_VALID one cycle later with KEY_BYTE = RX_BYTE.
- TX_DONE/TX_ERR outside WAIT_TX are ignored.

Optional Feature:
PS2_BOOT_CFG_EN
- Defined: reset enters INIT instead of IDLE. An internal requester runs two commands with the same SEND/ACK/RETRY rules:
  - 0xF9 (LEN = 0), then
  - 0xF0 followed by 0x03 (LEN = 1).
  - External REQs are ignored during INIT. INIT_DONE rises after the second command completes or fails, then the block goes to IDLE.
  - A failed boot command does not pulse ERR0/ERR1.
- Undefined: no INIT state; INIT_DONE = 1 from the first cycle after reset deasserts.

Test Plan:
- Single command: REQ0 = 1, LEN = 0, CMD = 0x00ED; after TX_DONE, drive RX 0xFA -> one TX_START with TX_BYTE = 0xED; DONE0 pulses 1 cycle; BUSY back low after HOLD.
- Two-byte command: REQ1, LEN = 1, CMD = 0x02ED, each byte acked with 0xFA -> TX_BYTE 0xED then 0x02; single DONE1 pulse after the second 0xFA.
- Arbitration: REQ0 and REQ1 asserted in the same cycle after reset -> requester 0 served first, then requester 1. Repeat the tie -> requester 0 served first again, since rr_last = 1 after the first pair.
- Resend and fail: reply 0xFE three times -> 3 TX_STARTs of the same byte, ERR0 pulses, no DONE0. Reply 0xFE once then 0xFA -> DONE0 after 2 attempts.
- Timeout with interleaved key: ACK_TIMEOUT = 100, drive RX 0x1C in WAIT_ACK, then no response -> KEY_VALID with 0x1C; retry at cycle 100 after TX_DONE; TX_ERR also triggers an immediate retry.
- Reset mid-WAIT_ACK: assert RESET -> next cycle all outputs 0, no DONE/ERR. With PS2_BOOT_CFG_EN, TX_BYTE sequence after reset is 0xF9, 0xF0, 0x03, and INIT_DONE rises after the last ack.

Source files
------------

// File: rtl/ps2_cmd_scheduler.sv
// ps2_cmd_scheduler: host-side PS/2 command scheduler.
// Arbitrates two requesters (round-robin on ties), sends each 1- or 2-byte command
// through the shared host-to-device byte transmitter, checks ACK (0xFA) / RESEND (0xFE)
// responses with retry and timeout, and forwards unconsumed device bytes as scan bytes.
// Build option: define PS2_BOOT_CFG_EN to run a boot configuration out of reset
// (0xF9, then 0xF0 0x03) before external requests are accepted.
module ps2_cmd_scheduler #(
   parameter int unsigned ACK_TIMEOUT = 800000,
   parameter int unsigned MAX_RETRY   = 3
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        REQ0,
   input  logic        REQ0_LEN,
   input  logic [15:0] REQ0_CMD,
   output logic        DONE0,
   output logic        ERR0,
   input  logic        REQ1,
   input  logic        REQ1_LEN,
   input  logic [15:0] REQ1_CMD,
   output logic        DONE1,
   output logic        ERR1,
   output logic        TX_START,
   output logic [7:0]  TX_BYTE,
   input  logic        TX_DONE,
   input  logic        TX_ERR,
   input  logic        RX_VALID,
   input  logic [7:0]  RX_BYTE,
   output logic        KEY_VALID,
   output logic [7:0]  KEY_BYTE,
   output logic        BUSY,
   output logic        INIT_DONE
);

   localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);
   localparam int unsigned RW = $clog2(MAX_RETRY + 1);

   localparam logic [7:0] RespAck    = 8'hFA;
   localparam logic [7:0] RespResend = 8'hFE;

   typedef enum logic [2:0] {
      StIdle, StSend, StWaitTx, StWaitAck, StRetry, StDone, StHold, StInit
   } state_e;

   state_e          state_q;
   logic            rr_last_q;
   logic            owner_q;
   logic [15:0]     cmd_q;
   logic            len_q;
   logic            byte_idx_q;
   logic [RW-1:0]   retry_cnt_q;
   logic [TW-1:0]   timer_q;

   logic            grant;
   logic [7:0]      cur_byte;
   logic            rx_consumed;
   logic [RW-1:0]   retry_next;
   logic            timed_out;
   logic            boot_active;

`ifdef PS2_BOOT_CFG_EN
   logic            boot_q;
   logic            boot_idx_q;
   assign boot_active = boot_q;
`else
   assign boot_active = 1'b0;
`endif

   // Grant decode, current byte select and response classification
   always_comb begin
      grant       = (REQ0 && REQ1) ? ~rr_last_q : REQ1;
      cur_byte    = byte_idx_q ? cmd_q[15:8] : cmd_q[7:0];
      rx_consumed = (state_q == StWaitAck) && RX_VALID &&
                    ((RX_BYTE == RespAck) || (RX_BYTE == RespResend));
      retry_next  = retry_cnt_q + 1'b1;
      // >= so a timeout masked by a coinciding RX byte fires on the next cycle
      timed_out   = (timer_q >= TW'(ACK_TIMEOUT - 1));
   end

   // Command sequencing FSM with registered handshake outputs
   always_ff @(posedge CLK) begin
      if (RESET) begin
`ifdef PS2_BOOT_CFG_EN
         state_q    <= StInit;
         boot_q     <= 1'b1;
         boot_idx_q <= 1'b0;
         INIT_DONE  <= 1'b0;
`else
         state_q    <= StIdle;
`endif
         rr_last_q   <= 1'b1;
         owner_q     <= 1'b0;
         cmd_q       <= '0;
         len_q       <= 1'b0;
         byte_idx_q  <= 1'b0;
         retry_cnt_q <= '0;
         timer_q     <= '0;
         TX_START    <= 1'b0;
         TX_BYTE     <= 8'h00;
         DONE0       <= 1'b0;
         DONE1       <= 1'b0;
         ERR0        <= 1'b0;
         ERR1        <= 1'b0;
         BUSY        <= 1'b0;
      end else begin
         TX_START <= 1'b0;
         DONE0    <= 1'b0;
         DONE1    <= 1'b0;
         ERR0     <= 1'b0;
         ERR1     <= 1'b0;
         case (state_q)
            StIdle: begin
               if (REQ0 || REQ1) begin
                  owner_q     <= grant;
                  rr_last_q   <= grant;
                  cmd_q       <= grant ? REQ1_CMD : REQ0_CMD;
                  len_q       <= grant ? REQ1_LEN : REQ0_LEN;
                  byte_idx_q  <= 1'b0;
                  retry_cnt_q <= '0;
                  BUSY        <= 1'b1;
                  state_q     <= StSend;
               end
            end
            StSend: begin
               TX_START <= 1'b1;
               TX_BYTE  <= cur_byte;
               state_q  <= StWaitTx;
            end
            StWaitTx: begin
               if (TX_DONE) begin
                  timer_q <= '0;
                  state_q <= StWaitAck;
               end else if (TX_ERR) begin
                  state_q <= StRetry;
               end
            end
            StWaitAck: begin
               if (RX_VALID && (RX_BYTE == RespAck)) begin
                  if (byte_idx_q == len_q) begin
                     state_q <= StDone;
                  end else begin
                     byte_idx_q  <= 1'b1;
                     retry_cnt_q <= '0;
                     state_q     <= StSend;
                  end
               end else if (RX_VALID && (RX_BYTE == RespResend)) begin
                  state_q <= StRetry;
               end else if (!RX_VALID && timed_out) begin
                  state_q <= StRetry;
               end else begin
                  timer_q <= timer_q + 1'b1;
               end
            end
            StRetry: begin
               retry_cnt_q <= retry_next;
               if (retry_next == RW'(MAX_RETRY)) begin
                  ERR0    <= !boot_active && !owner_q;
                  ERR1    <= !boot_active && owner_q;
                  state_q <= StHold;
               end else begin
                  state_q <= StSend;
               end
            end
            StDone: begin
               DONE0   <= !boot_active && !owner_q;
               DONE1   <= !boot_active && owner_q;
               state_q <= StHold;
            end
            StHold: begin
`ifdef PS2_BOOT_CFG_EN
               if (boot_q && !boot_idx_q) begin
                  boot_idx_q <= 1'b1;
                  state_q    <= StInit;
               end else begin
                  if (boot_q) begin
                     boot_q    <= 1'b0;
                     INIT_DONE <= 1'b1;
                  end
                  BUSY    <= 1'b0;
                  state_q <= StIdle;
               end
`else
               BUSY    <= 1'b0;
               state_q <= StIdle;
`endif
            end
`ifdef PS2_BOOT_CFG_EN
            StInit: begin
               // Boot command 0: 0xF9 alone; boot command 1: 0xF0 then 0x03
               cmd_q       <= boot_idx_q ? 16'h03F0 : 16'h00F9;
               len_q       <= boot_idx_q;
               byte_idx_q  <= 1'b0;
               retry_cnt_q <= '0;
               BUSY        <= 1'b1;
               state_q     <= StSend;
            end
`endif
            default: begin
               BUSY    <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

   // Forward every RX byte not consumed as a command response
   always_ff @(posedge CLK) begin
      if (RESET) begin
         KEY_VALID <= 1'b0;
         KEY_BYTE  <= 8'h00;
      end else begin
         KEY_VALID <= RX_VALID && !rx_consumed;
         if (RX_VALID && !rx_consumed) begin
            KEY_BYTE <= RX_BYTE;
         end
      end
   end

`ifndef PS2_BOOT_CFG_EN
   // Without boot configuration the link is ready as soon as reset releases
   always_ff @(posedge CLK) begin
      if (RESET) begin
         INIT_DONE <= 1'b0;
      end else begin
         INIT_DONE <= 1'b1;
      end
   end
`endif

endmodule
